buffer_a_seq: RTL and testbench
===============================

BUFFER_A_SEQ -- requirements
Module: buffer_a_seq

Interface
REQ-001 Parameter MMU_SIZE, default 10: systolic array edge; maximum legal dim_x/dim_y.
REQ-002 Parameter NUM_BUF, default 10: number of A-buffers sequenced; legal indices 0..NUM_BUF-1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  1  host request present.
REQ-006 req_ready  output  1  controller accepts a request this cycle.
REQ-007 req_cmd  input  2  request opcode: 01 LOAD, 10 SEND, 11 CLEAR, 00 ignored.
REQ-008 req_buf  input  5  target buffer index.
REQ-009 req_dim_x, req_dim_y  input  8 each  matrix dimensions (LOAD only).
REQ-010 data_valid  input  1  upstream A element present this cycle (LOAD only).
REQ-011 cmd  output  2  command to the buffer; 00 NONE except during ISSUE.
REQ-012 buffer  output  5  buffer index to the buffer.
REQ-013 dim_x_out, dim_y_out  output  8 each  dimensions forwarded to the buffer.
REQ-014 stop  output  1  stall to the buffer.
REQ-015 busy  output  1  high in any state other than IDLE.
REQ-016 done  output  1  one-cycle pulse when an operation completes.
REQ-017 err  output  1  one-cycle pulse when a request is rejected.

Function
REQ-018 FSM states: IDLE, ISSUE, RUN, DONE; encoding is free.
REQ-019 req_ready is high only in IDLE; a handshake is req_valid and req_ready both high.
REQ-020 On handshake with req_cmd 00: no effect; remain IDLE.
REQ-021 Rejection (err pulse next cycle, stay IDLE, no cmd issued): req_buf >= NUM_BUF; LOAD with dim_x or dim_y equal to 0 or greater than MMU_SIZE; SEND to a buffer whose stored dim_y is 0.
REQ-022 On accepted handshake: latch opcode, index and dims; IDLE->ISSUE.
REQ-023 Per-buffer shadow table of (dim_x, dim_y): LOAD writes the request dims, CLEAR writes 0/0, SEND leaves it unchanged; the table is updated at acceptance.
REQ-024 ISSUE lasts exactly 1 cycle: cmd = latched opcode, buffer = latched index, dim_x_out/dim_y_out = request dims (LOAD) or table entry (SEND/CLEAR); then ->RUN.
REQ-025 On entering RUN, the cycle counter is loaded with: LOAD dim_x*dim_y (16-bit product, no overflow for MMU_SIZE <= 255); SEND stored dim_y; CLEAR MMU_SIZE.
REQ-026 RUN counter rule: LOAD decrements only in cycles with data_valid high; SEND and CLEAR decrement every cycle.
REQ-027 RUN->DONE in the cycle the counter decrements from 1 to 0.
REQ-028 DONE lasts 1 cycle with done=1, then ->IDLE.
REQ-029 stop = 1 only in RUN with latched opcode LOAD and data_valid=0; stop = 0 in all other cases.
REQ-030 In every state except ISSUE, cmd = 00, and buffer/dim outputs hold their last issued values.
REQ-031 data_valid is ignored outside LOAD RUN.
REQ-032 req_valid held high while busy is not consumed; it is accepted in the first IDLE cycle.

Reset
REQ-033 With rst high at a clock edge, the block enters IDLE and all outputs are 0 on the next cycle, except req_ready, which is 1; all table entries are cleared to 0/0 and the counter is cleared to 0.
REQ-034 Reset mid-operation aborts the operation without a done pulse; the host re-issues CLEAR for buffer consistency.

Verification
REQ-035 LOAD buf 3, dims 4x2, data_valid constant 1 -> cmd=01 and buffer=3 for 1 cycle, then RUN for 8 cycles, done 1 cycle later; table[3]=4/2.
REQ-036 Same LOAD with data_valid low in RUN cycles 2-4 -> stop high exactly in those 3 cycles; RUN lasts 11 cycles.
REQ-037 SEND buf 3 after REQ-035 -> cmd=10, dim_y_out=2, RUN 2 cycles, done; SEND buf 5 with an empty entry -> err pulse, no cmd.
REQ-038 CLEAR buf 3 -> cmd=11, RUN 10 cycles, done; table[3]=0/0; a subsequent SEND to buf 3 -> err.
REQ-039 Illegal requests (buf 12; LOAD 0x4; LOAD 11x1) -> err each time, state stays IDLE, cmd stays 00.
REQ-040 rst asserted in LOAD RUN cycle 3 -> next cycle busy=0, req_ready=1, stop=0, done never pulses.

Source files
------------

// File: rtl/buffer_a_seq_if.sv
// Host request / buffer command bundle for the A-buffer sequencer.
// The slave modport is the sequencer side; the master modport is the host/buffer side.
interface buffer_a_seq_if;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_cmd;
  logic [4:0] req_buf;
  logic [7:0] req_dim_x;
  logic [7:0] req_dim_y;
  logic       data_valid;
  logic [1:0] cmd;
  logic [4:0] buffer;
  logic [7:0] dim_x_out;
  logic [7:0] dim_y_out;
  logic       stop;
  logic       busy;
  logic       done;
  logic       err;

  modport slave (
    input  req_valid, req_cmd, req_buf, req_dim_x, req_dim_y, data_valid,
    output req_ready, cmd, buffer, dim_x_out, dim_y_out, stop, busy, done, err
  );

  modport master (
    output req_valid, req_cmd, req_buf, req_dim_x, req_dim_y, data_valid,
    input  req_ready, cmd, buffer, dim_x_out, dim_y_out, stop, busy, done, err
  );
endinterface

// File: rtl/buffer_a_seq.sv
// Sequences LOAD/SEND/CLEAR operations onto a bank of A-buffers, keeping a shadow
// table of each buffer's dimensions so SENDs can be validated and sized.
module buffer_a_seq #(
  parameter int unsigned MMU_SIZE = 10,
  parameter int unsigned NUM_BUF  = 10
) (
  input logic            clk,
  input logic            rst,
  buffer_a_seq_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StRun, StDone} state_e;

  localparam logic [1:0] OpNone  = 2'b00;
  localparam logic [1:0] OpLoad  = 2'b01;
  localparam logic [1:0] OpSend  = 2'b10;
  localparam logic [1:0] OpClear = 2'b11;
  localparam int unsigned IdxW   = (NUM_BUF > 1) ? $clog2(NUM_BUF) : 1;

  state_e      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [4:0]  idx_q, idx_d;
  logic [7:0]  dx_q, dx_d;
  logic [7:0]  dy_q, dy_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [7:0]  tab_x_q [NUM_BUF];
  logic [7:0]  tab_x_d [NUM_BUF];
  logic [7:0]  tab_y_q [NUM_BUF];
  logic [7:0]  tab_y_d [NUM_BUF];

  logic [IdxW-1:0] tidx;
  logic            buf_ok;
  logic            dims_ok;
  logic [7:0]      rd_x;
  logic [7:0]      rd_y;
  logic            reject;
  logic            dec;

  assign tidx    = bus.req_buf[IdxW-1:0];
  assign buf_ok  = {27'd0, bus.req_buf} < NUM_BUF;
  assign dims_ok = (bus.req_dim_x != 8'd0) && (bus.req_dim_y != 8'd0) &&
                   (bus.req_dim_x <= 8'(MMU_SIZE)) && (bus.req_dim_y <= 8'(MMU_SIZE));
  assign rd_x    = buf_ok ? tab_x_q[tidx] : 8'd0;
  assign rd_y    = buf_ok ? tab_y_q[tidx] : 8'd0;
  assign reject  = !buf_ok ||
                   ((bus.req_cmd == OpLoad) && !dims_ok) ||
                   ((bus.req_cmd == OpSend) && (rd_y == 8'd0));
  assign dec     = (op_q != OpLoad) || bus.data_valid;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    tab_x_d = tab_x_q;
    tab_y_d = tab_y_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid && (bus.req_cmd != OpNone)) begin
          if (reject) begin
            err_d = 1'b1;
          end else begin
            state_d = StIssue;
            op_d    = bus.req_cmd;
            idx_d   = bus.req_buf;
            unique case (bus.req_cmd)
              OpLoad: begin
                dx_d          = bus.req_dim_x;
                dy_d          = bus.req_dim_y;
                tab_x_d[tidx] = bus.req_dim_x;
                tab_y_d[tidx] = bus.req_dim_y;
              end
              OpSend: begin
                dx_d = rd_x;
                dy_d = rd_y;
              end
              default: begin
                // CLEAR forwards the entry as it reads after the wipe
                dx_d          = 8'd0;
                dy_d          = 8'd0;
                tab_x_d[tidx] = 8'd0;
                tab_y_d[tidx] = 8'd0;
              end
            endcase
          end
        end
      end
      StIssue: begin
        state_d = StRun;
        unique case (op_q)
          OpLoad:  cnt_d = {8'd0, dx_q} * {8'd0, dy_q};
          OpSend:  cnt_d = {8'd0, dy_q};
          OpClear: cnt_d = 16'(MMU_SIZE);
          default: cnt_d = 16'd0;
        endcase
      end
      StRun: begin
        if (dec) begin
          cnt_d = cnt_q - 16'd1;
          if (cnt_q == 16'd1) state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= OpNone;
      idx_q   <= 5'd0;
      dx_q    <= 8'd0;
      dy_q    <= 8'd0;
      cnt_q   <= 16'd0;
      err_q   <= 1'b0;
      tab_x_q <= '{default: '0};
      tab_y_q <= '{default: '0};
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      tab_x_q <= tab_x_d;
      tab_y_q <= tab_y_d;
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.busy      = (state_q != StIdle);
  assign bus.done      = (state_q == StDone);
  assign bus.err       = err_q;
  assign bus.cmd       = (state_q == StIssue) ? op_q : OpNone;
  assign bus.buffer    = idx_q;
  assign bus.dim_x_out = dx_q;
  assign bus.dim_y_out = dy_q;
  assign bus.stop      = (state_q == StRun) && (op_q == OpLoad) && !bus.data_valid;

endmodule

// File: tb/tb_buffer_a_seq.sv
// Directed-vector bench for buffer_a_seq: a request table plus reset-abort and
// held-request sequences.
module tb_buffer_a_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  buffer_a_seq_if bus ();

  buffer_a_seq #(
    .MMU_SIZE (10),
    .NUM_BUF  (10)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0] op;
    logic [4:0] bidx;
    logic [7:0] dx;
    logic [7:0] dy;
    int         gap_s;
    int         gap_l;
    int         kind;     // 0 accepted, 1 rejected, 2 ignored opcode
    logic [7:0] edx;
    logic [7:0] edy;
    int         erun;
    bit         chk_dims;
  } vec_t;

  vec_t       vecs[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [4:0] last_buf = 5'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int  k;
    bit  seen;
    logic dv;
    @(negedge clk);
    chk($sformatf("v%0d ready", id), {31'd0, bus.req_ready}, 1);
    bus.req_cmd    = v.op;
    bus.req_buf    = v.bidx;
    bus.req_dim_x  = v.dx;
    bus.req_dim_y  = v.dy;
    bus.data_valid = 1'b0;
    bus.req_valid  = 1'b1;
    @(negedge clk);
    bus.req_valid  = 1'b0;
    case (v.kind)
      1: begin
        chk($sformatf("v%0d err", id), {31'd0, bus.err}, 1);
        chk($sformatf("v%0d err_busy", id), {31'd0, bus.busy}, 0);
        chk($sformatf("v%0d err_cmd", id), {30'd0, bus.cmd}, 0);
        chk($sformatf("v%0d err_buf_hold", id), {27'd0, bus.buffer}, {27'd0, last_buf});
        @(negedge clk);
        chk($sformatf("v%0d err_pulse", id), {31'd0, bus.err}, 0);
      end
      2: begin
        chk($sformatf("v%0d nop_err", id), {31'd0, bus.err}, 0);
        chk($sformatf("v%0d nop_busy", id), {31'd0, bus.busy}, 0);
        chk($sformatf("v%0d nop_cmd", id), {30'd0, bus.cmd}, 0);
      end
      default: begin
        chk($sformatf("v%0d cmd", id), {30'd0, bus.cmd}, {30'd0, v.op});
        chk($sformatf("v%0d buffer", id), {27'd0, bus.buffer}, {27'd0, v.bidx});
        chk($sformatf("v%0d busy", id), {31'd0, bus.busy}, 1);
        if (v.chk_dims) begin
          chk($sformatf("v%0d dim_x", id), {24'd0, bus.dim_x_out}, {24'd0, v.edx});
          chk($sformatf("v%0d dim_y", id), {24'd0, bus.dim_y_out}, {24'd0, v.edy});
        end
        last_buf = v.bidx;
        k    = 0;
        seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
          @(negedge clk);
          if (bus.done) begin
            seen = 1'b1;
            break;
          end
          k++;
          dv = (v.op == 2'b01) && !((k >= v.gap_s) && (k < v.gap_s + v.gap_l));
          bus.data_valid = dv;
          #1;
          chk($sformatf("v%0d stop@%0d", id, k), {31'd0, bus.stop},
              {31'd0, (v.op == 2'b01) && !dv});
          chk($sformatf("v%0d run_cmd@%0d", id, k), {30'd0, bus.cmd}, 0);
        end
        bus.data_valid = 1'b0;
        chk($sformatf("v%0d done_seen", id), {31'd0, seen}, 1);
        chk($sformatf("v%0d run_len", id), k, v.erun);
        @(negedge clk);
        chk($sformatf("v%0d done_pulse", id), {31'd0, bus.done}, 0);
        chk($sformatf("v%0d idle_ready", id), {31'd0, bus.req_ready}, 1);
      end
    endcase
  endtask

  initial begin
    int   dcnt;
    int   issues;
    bit   seen;
    vec_t v;

    bus.req_valid  = 1'b0;
    bus.req_cmd    = 2'b00;
    bus.req_buf    = 5'd0;
    bus.req_dim_x  = 8'd0;
    bus.req_dim_y  = 8'd0;
    bus.data_valid = 1'b0;

    //      op     buf    dx     dy     gs gl kind edx    edy    run dims
    vecs.push_back('{2'd1, 5'd3,  8'd4,  8'd2,  0, 0, 0, 8'd4,  8'd2,  8,  1'b1});
    vecs.push_back('{2'd1, 5'd3,  8'd4,  8'd2,  2, 3, 0, 8'd4,  8'd2,  11, 1'b1});
    vecs.push_back('{2'd2, 5'd3,  8'd0,  8'd0,  0, 0, 0, 8'd4,  8'd2,  2,  1'b1});
    vecs.push_back('{2'd2, 5'd5,  8'd0,  8'd0,  0, 0, 1, 8'd0,  8'd0,  0,  1'b0});
    vecs.push_back('{2'd3, 5'd3,  8'd0,  8'd0,  0, 0, 0, 8'd0,  8'd0,  10, 1'b0});
    vecs.push_back('{2'd2, 5'd3,  8'd0,  8'd0,  0, 0, 1, 8'd0,  8'd0,  0,  1'b0});
    vecs.push_back('{2'd1, 5'd12, 8'd2,  8'd2,  0, 0, 1, 8'd0,  8'd0,  0,  1'b0});
    vecs.push_back('{2'd1, 5'd1,  8'd0,  8'd4,  0, 0, 1, 8'd0,  8'd0,  0,  1'b0});
    vecs.push_back('{2'd1, 5'd1,  8'd11, 8'd1,  0, 0, 1, 8'd0,  8'd0,  0,  1'b0});
    vecs.push_back('{2'd1, 5'd10, 8'd2,  8'd2,  0, 0, 1, 8'd0,  8'd0,  0,  1'b0});
    vecs.push_back('{2'd1, 5'd9,  8'd10, 8'd3,  0, 0, 0, 8'd10, 8'd3,  30, 1'b1});
    vecs.push_back('{2'd0, 5'd9,  8'd1,  8'd1,  0, 0, 2, 8'd0,  8'd0,  0,  1'b0});
    vecs.push_back('{2'd2, 5'd9,  8'd0,  8'd0,  0, 0, 0, 8'd10, 8'd3,  3,  1'b1});

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst ready", {31'd0, bus.req_ready}, 1);
    chk("rst busy",  {31'd0, bus.busy}, 0);
    chk("rst done",  {31'd0, bus.done}, 0);
    chk("rst err",   {31'd0, bus.err}, 0);
    chk("rst stop",  {31'd0, bus.stop}, 0);
    chk("rst cmd",   {30'd0, bus.cmd}, 0);
    chk("rst buf",   {27'd0, bus.buffer}, 0);
    chk("rst dims",  {16'd0, bus.dim_x_out, bus.dim_y_out}, 0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset during LOAD RUN cycle 3 aborts silently and wipes the table
    @(negedge clk);
    bus.req_cmd = 2'b01; bus.req_buf = 5'd4; bus.req_dim_x = 8'd3; bus.req_dim_y = 8'd3;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("abort issue", {30'd0, bus.cmd}, 1);
    bus.data_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort in_run", {31'd0, bus.busy}, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("abort busy",  {31'd0, bus.busy}, 0);
    chk("abort ready", {31'd0, bus.req_ready}, 1);
    chk("abort stop",  {31'd0, bus.stop}, 0);
    chk("abort done",  {31'd0, bus.done}, 0);
    rst = 1'b0;
    last_buf = 5'd0;
    dcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) dcnt++;
    end
    chk("abort no_done", dcnt, 0);
    bus.data_valid = 1'b0;
    v = '{2'd2, 5'd9, 8'd0, 8'd0, 0, 0, 1, 8'd0, 8'd0, 0, 1'b0};
    run_vec(v, 100);

    // Held request is consumed once per IDLE visit
    @(negedge clk);
    bus.req_cmd = 2'b01; bus.req_buf = 5'd2; bus.req_dim_x = 8'd1; bus.req_dim_y = 8'd1;
    bus.data_valid = 1'b1;
    bus.req_valid  = 1'b1;
    issues = 0;
    seen   = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.cmd == 2'b01) issues++;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("hold done1", {31'd0, seen}, 1);
    chk("hold issues", issues, 1);
    @(negedge clk);
    chk("hold idle_ready", {31'd0, bus.req_ready}, 1);
    chk("hold idle_busy",  {31'd0, bus.busy}, 0);
    @(negedge clk);
    chk("hold reissue", {30'd0, bus.cmd}, 1);
    bus.req_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    chk("hold done2", {31'd0, seen}, 1);
    bus.data_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
